sd_frame_scheduler: RTL and testbench

Sequences whole-frame playback reads through the SD bus master on the 100 MHz `clk_100` domain. Once the card reports ready, it issues consecutive single-block read requests that fill one half of a double-buffered frame store. It swaps display/fill halves on a frame-rate tick and repeats until the last frame. It sits between `sd_bus_master` (block read port) and the video/frame-buffer logic.

---
 rtl/sd_frame_scheduler_pkg.sv | 24 ++
 rtl/sd_frame_scheduler_if.sv | 27 ++
 rtl/sd_frame_scheduler_tick_gen.sv | 27 ++
 rtl/sd_frame_scheduler.sv | 146 ++++++++++++++
 tb/tb_sd_frame_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_frame_scheduler_pkg.sv
// Shared types and widths for the SD frame playback scheduler.
// Holds the FSM state encoding and a saturating counter helper.
package sd_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_FILLED,
        ST_FINISHED,
        ST_ERR
    } state_t;

    localparam int BLOCK_BYTES = 512;
    localparam int ADDR_W      = 32;
    localparam int FRAME_W     = 13;
    localparam int UNDER_W     = 8;

    function automatic logic [UNDER_W-1:0] sat_inc(input logic [UNDER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sd_frame_scheduler_if.sv
// Block read port between the frame scheduler (master) and the SD bus master (slave).
interface sd_frame_scheduler_if;
    import sd_frame_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_done;
    logic              rd_error;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_done,
        input  rd_error
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_done,
        output rd_error
    );

endinterface

// File: rtl/sd_frame_scheduler_tick_gen.sv
// Frame-period tick: counts 0..TICKS_PER_FRAME-1 while enabled, held at 0 by restart.
module frame_tick_gen #(
    parameter int TICKS_PER_FRAME = 3333333
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_FRAME - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = enable && !restart && (r_count == LAST);

endmodule

// File: rtl/sd_frame_scheduler.sv
// Issues single-block reads to fill one half of a double-buffered frame store,
// swapping display/fill halves on each frame tick until the clip ends.
module sd_frame_scheduler
    import sd_frame_pkg::*;
#(
    parameter int                BLOCKS_PER_FRAME = 12,
    parameter int                FRAME_COUNT      = 6572,
    parameter int                TICKS_PER_FRAME  = 3333333,
    parameter logic [ADDR_W-1:0] START_BLOCK      = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 card_ready,
    sd_frame_scheduler_if.master rd,
    output logic                 fill_buf,
    output logic                 show_buf,
    output logic                 frame_ready,
    output logic [FRAME_W-1:0]   frame_index,
    output logic [UNDER_W-1:0]   underrun_cnt,
    output logic                 done,
    output logic                 error
);

    localparam int BLK_W = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;
    localparam logic [BLK_W-1:0]   LAST_BLK   = BLK_W'(BLOCKS_PER_FRAME - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAME_COUNT - 1);

    state_t              r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [BLK_W-1:0]    r_blk_idx;
    logic                r_fill;
    logic                r_show;
    logic                r_frame_ready;
    logic [FRAME_W-1:0]  r_frame_index;
    logic [UNDER_W-1:0]  r_underrun;
    logic                r_done;
    logic                r_error;
    logic                r_started;

    logic w_tick;
    logic w_tick_en;
    logic w_last_blk;

    assign w_tick_en  = (r_state != ST_FINISHED) && (r_state != ST_ERR);
    assign w_last_blk = (r_blk_idx == LAST_BLK);

    // Counter stays parked at zero until the first frame has been put on display.
    frame_tick_gen #(
        .TICKS_PER_FRAME (TICKS_PER_FRAME)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_tick_en),
        .restart (!r_started),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req         <= 1'b0;
            r_addr        <= START_BLOCK;
            r_blk_idx     <= '0;
            r_fill        <= 1'b0;
            r_show        <= 1'b1;
            r_frame_ready <= 1'b0;
            r_frame_index <= '0;
            r_underrun    <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_started     <= 1'b0;
        end else if (rd.rd_error) begin
            r_state       <= ST_ERR;
            r_req         <= 1'b0;
            r_error       <= 1'b1;
            r_frame_ready <= 1'b0;
        end else begin
            r_frame_ready <= 1'b0;
            // A tick coinciding with the last block's completion is not late; it is simply skipped.
            if (w_tick && (r_state != ST_FILLED) && !((r_state == ST_NEXT) && w_last_blk)) begin
                r_underrun <= sat_inc(r_underrun);
            end
            case (r_state)
                ST_IDLE: begin
                    if (card_ready) begin
                        r_state <= ST_ISSUE;
                        r_req   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (rd.rd_ack) begin
                        r_req   <= 1'b0;
                        r_state <= rd.rd_done ? ST_NEXT : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (rd.rd_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_addr <= r_addr + 1'b1;
                    if (w_last_blk) begin
                        r_blk_idx <= '0;
                        r_state   <= ST_FILLED;
                    end else begin
                        r_blk_idx <= r_blk_idx + 1'b1;
                        r_state   <= ST_ISSUE;
                        r_req     <= 1'b1;
                    end
                end
                ST_FILLED: begin
                    if (!r_started || w_tick) begin
                        r_show        <= r_fill;
                        r_fill        <= ~r_fill;
                        r_frame_ready <= 1'b1;
                        r_started     <= 1'b1;
                        if (r_frame_index == LAST_FRAME) begin
                            r_state <= ST_FINISHED;
                            r_done  <= 1'b1;
                        end else begin
                            r_frame_index <= r_frame_index + 1'b1;
                            r_state       <= ST_ISSUE;
                            r_req         <= 1'b1;
                        end
                    end
                end
                ST_FINISHED, ST_ERR: begin
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd.rd_req    = r_req;
    assign rd.rd_addr   = r_addr;
    assign fill_buf     = r_fill;
    assign show_buf     = r_show;
    assign frame_ready  = r_frame_ready;
    assign frame_index  = r_frame_index;
    assign underrun_cnt = r_underrun;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: tb/tb_sd_frame_scheduler.sv
// Self-checking bench: SD responder with configurable latencies, a behavioural
// playback model compared every cycle, and directed literal checks per scenario.
module tb_sd_frame_scheduler;

    localparam int BPF = 2;
    localparam int FC  = 3;
    localparam int T   = 50;
    localparam int SB  = 100;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        card_ready = 1'b0;
    logic        fill_buf, show_buf, frame_ready, done, error;
    logic [12:0] frame_index;
    logic [7:0]  underrun_cnt;

    sd_frame_scheduler_if bus ();

    sd_frame_scheduler #(
        .BLOCKS_PER_FRAME (BPF),
        .FRAME_COUNT      (FC),
        .TICKS_PER_FRAME  (T),
        .START_BLOCK      (32'd100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .card_ready   (card_ready),
        .rd           (bus),
        .fill_buf     (fill_buf),
        .show_buf     (show_buf),
        .frame_ready  (frame_ready),
        .frame_index  (frame_index),
        .underrun_cnt (underrun_cnt),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scenario knobs read by the SD responder
    int          sc_ack = 1, sc_done = 5;
    bit          sc_rand = 0;
    logic [31:0] sc_long = NONE, sc_err = NONE;
    bit          resp_flush = 1;

    // SD responder: acks after sc_ack extra request cycles, completes sc_done cycles after ack
    int          r_reqc = 0, r_ackd = 0, r_doned = 0, r_dcnt = 0;
    bit          r_phase = 0;
    logic [31:0] r_addr = '0;

    always @(negedge clk) begin : responder
        bus.rd_ack   = 1'b0;
        bus.rd_done  = 1'b0;
        bus.rd_error = 1'b0;
        if (resp_flush) begin
            r_reqc = 0; r_phase = 0; r_dcnt = 0;
        end else if (!r_phase) begin
            if (bus.rd_req) begin
                if (r_reqc == 0) begin
                    r_addr  = bus.rd_addr;
                    r_ackd  = sc_rand ? int'($urandom_range(0, 3)) : sc_ack;
                    if (r_addr == sc_long)
                        r_doned = 60;
                    else if (sc_rand)
                        r_doned = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 70))
                                                              : int'($urandom_range(0, 6));
                    else
                        r_doned = sc_done;
                end
                r_reqc++;
                if (r_reqc > r_ackd) begin
                    bus.rd_ack = 1'b1;
                    r_reqc = 0;
                    if (r_doned == 0) bus.rd_done = 1'b1;
                    else begin r_phase = 1; r_dcnt = 0; end
                end
            end
        end else begin
            r_dcnt++;
            if (r_addr == sc_err && r_dcnt == 2) begin
                bus.rd_error = 1'b1;
                r_phase = 0;
            end else if (r_dcnt == r_doned) begin
                bus.rd_done = 1'b1;
                r_phase = 0;
            end
        end
    end

    // Behavioural model: counts completed blocks and swaps; outputs follow from those counts
    int m_blocks, m_blk, m_swaps, m_since, m_und;
    bit m_req, m_full, m_adv, m_await, m_begun, m_started, m_err, m_fr;

    always @(posedge clk) begin : model_step
        bit tick, completing;
        cyc++;
        if (reset) begin
            m_blocks = 0; m_blk = 0; m_swaps = 0; m_since = 0; m_und = 0;
            m_req = 0; m_full = 0; m_adv = 0; m_await = 0; m_begun = 0;
            m_started = 0; m_err = 0; m_fr = 0;
        end else if (m_err) begin
            m_fr = 0;
        end else if (bus.rd_error) begin
            m_err = 1; m_req = 0; m_fr = 0;
        end else begin
            m_fr = 0;
            tick = m_started && (m_swaps < FC) && (m_since % T == T - 1);
            if (m_started && m_swaps < FC) m_since++;
            completing = m_adv && (m_blk + 1 == BPF);
            if (tick && !m_full && !completing && m_und < 255) m_und++;
            if (m_full) begin
                if (m_swaps == 0 || tick) begin
                    m_swaps++; m_fr = 1; m_full = 0;
                    if (!m_started) begin m_started = 1; m_since = 0; end
                    if (m_swaps < FC) m_req = 1;
                end
            end else if (m_adv) begin
                m_adv = 0; m_blocks++; m_blk++;
                if (m_blk == BPF) begin m_blk = 0; m_full = 1; end
                else m_req = 1;
            end else if (m_req) begin
                if (bus.rd_ack) begin
                    m_req = 0;
                    if (bus.rd_done) m_adv = 1; else m_await = 1;
                end
            end else if (m_await) begin
                if (bus.rd_done) begin m_await = 0; m_adv = 1; end
            end else if (!m_begun && card_ready) begin
                m_begun = 1; m_req = 1;
            end
        end
    end

    int req_addr_q[$], req_rise_q[$], req_len_q[$], fr_cyc_q[$], fr_show_q[$];
    bit          prev_req = 0;
    logic [31:0] prev_addr = '0;
    int          run_len = 0;

    always @(posedge clk) begin : compare
        #1;
        if (chk_en) begin
            check("rd_req", bus.rd_req, m_req);
            check("rd_addr", bus.rd_addr, 32'(SB + m_blocks));
            check("fill_buf", fill_buf, m_swaps % 2);
            check("show_buf", show_buf, 1 - (m_swaps % 2));
            check("frame_ready", frame_ready, m_fr);
            check("frame_index", frame_index, (m_swaps < FC) ? m_swaps : FC - 1);
            check("underrun_cnt", underrun_cnt, m_und);
            check("done", done, m_swaps == FC);
            check("error", error, m_err);
            if (bus.rd_error) begin
                check("error_next_cycle", error, 1);
                check("req_low_on_error", bus.rd_req, 0);
            end
            if (bus.rd_req && !prev_req) begin
                req_addr_q.push_back(int'(bus.rd_addr));
                req_rise_q.push_back(cyc);
            end
            if (bus.rd_req && prev_req) check("addr_stable", bus.rd_addr, prev_addr);
            if (bus.rd_req) run_len++;
            else if (prev_req) begin req_len_q.push_back(run_len); run_len = 0; end
            if (frame_ready) begin
                fr_cyc_q.push_back(cyc);
                fr_show_q.push_back(int'(show_buf));
            end
            $display("cyc %0d req=%0b addr=%0d ack=%0b done_in=%0b fill=%0b show=%0b fr=%0b idx=%0d und=%0d done=%0b err=%0b",
                     cyc, bus.rd_req, bus.rd_addr, bus.rd_ack, bus.rd_done, fill_buf, show_buf,
                     frame_ready, frame_index, underrun_cnt, done, error);
        end
        prev_req  = bus.rd_req;
        prev_addr = bus.rd_addr;
    end

    task automatic clear_logs();
        req_addr_q.delete(); req_rise_q.delete(); req_len_q.delete();
        fr_cyc_q.delete(); fr_show_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_req"}, bus.rd_req, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 100);
        check({tag, "_fill_buf"}, fill_buf, 0);
        check({tag, "_show_buf"}, show_buf, 1);
        check({tag, "_frame_ready"}, frame_ready, 0);
        check({tag, "_frame_index"}, frame_index, 0);
        check({tag, "_underrun"}, underrun_cnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic start_run(input int ack, input int dn, input bit rnd,
                             input logic [31:0] long_a, input logic [31:0] err_a, input string tag);
        @(negedge clk);
        reset = 1'b1; card_ready = 1'b0; resp_flush = 1'b1;
        sc_ack = ack; sc_done = dn; sc_rand = rnd; sc_long = long_a; sc_err = err_a;
        repeat (2) @(negedge clk);
        reset = 1'b0; resp_flush = 1'b0;
        clear_logs();
        @(negedge clk);
        check_reset_values(tag);
        card_ready = 1'b1;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || error) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_completes"}, done | error, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_en = 1;

        // Nominal playback
        start_run(1, 5, 0, NONE, NONE, "nominal");
        wait_end("nominal");
        check("nom_req_count", req_addr_q.size(), 6);
        foreach (req_addr_q[i]) check("nom_req_addr", req_addr_q[i], 100 + i);
        check("nom_fr_count", fr_cyc_q.size(), 3);
        if (fr_cyc_q.size() == 3) begin
            check("nom_swap_spacing", fr_cyc_q[2] - fr_cyc_q[1], 50);
            check("nom_show0", fr_show_q[0], 0);
            check("nom_show1", fr_show_q[1], 1);
            check("nom_show2", fr_show_q[2], 0);
        end
        check("nom_done", done, 1);
        check("nom_underrun", underrun_cnt, 0);

        // Slow acknowledge: request held for 7 extra cycles
        start_run(7, 5, 0, NONE, NONE, "ack7");
        wait_end("ack7");
        check("ack7_req_count", req_addr_q.size(), 6);
        foreach (req_len_q[i]) check("ack7_hold_len", req_len_q[i], 8);

        // Late block on frame 1 forces one underrun
        start_run(1, 5, 0, 32'd102, NONE, "underrun");
        wait_end("underrun");
        check("und_count", underrun_cnt, 1);
        check("und_fr_count", fr_cyc_q.size(), 3);
        if (fr_cyc_q.size() == 3) begin
            check("und_swap2_delay", fr_cyc_q[1] - fr_cyc_q[0], 100);
            check("und_swap3_spacing", fr_cyc_q[2] - fr_cyc_q[1], 50);
            check("und_show1", fr_show_q[1], 1);
        end

        // Read error on block 103
        start_run(1, 5, 0, NONE, 32'd103, "rderr");
        wait_end("rderr");
        repeat (20) @(negedge clk);
        check("err_flag", error, 1);
        check("err_done", done, 0);
        check("err_req", bus.rd_req, 0);
        check("err_req_count", req_addr_q.size(), 4);
        if (req_addr_q.size() > 0) check("err_last_addr", req_addr_q[req_addr_q.size() - 1], 103);

        // Reset while waiting on block 102, with the aborted read completing afterwards
        start_run(1, 5, 0, NONE, NONE, "rst_pre");
        k = 0;
        while (!(r_phase && r_addr == 32'd102 && r_dcnt == 2) && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst_trigger_reached", k < 500, 1);
        reset = 1'b1; card_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        clear_logs();
        check_reset_values("rst_mid");
        card_ready = 1'b1;
        wait_end("rst_post");
        check("rst_req_count", req_addr_q.size(), 6);
        if (req_addr_q.size() > 0) check("rst_first_addr", req_addr_q[0], 100);
        check("rst_done", done, 1);

        // Ack and done in the same cycle
        start_run(1, 0, 0, NONE, NONE, "same");
        wait_end("same");
        check("same_done", done, 1);
        check("same_req_count", req_addr_q.size(), 6);
        if (req_rise_q.size() >= 4) begin
            check("same_gap_f0", req_rise_q[1] - req_rise_q[0], 3);
            check("same_gap_f1", req_rise_q[3] - req_rise_q[2], 3);
        end

        // Randomised latencies, model-checked every cycle
        for (int r = 0; r < 3; r++) begin
            start_run(0, 0, 1, NONE, NONE, "rand");
            wait_end("rand");
            check("rand_done", done, 1);
            check("rand_req_count", req_addr_q.size(), 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
